// File: rtl/eip_step_controller_if.sv
// eip_step_controller_if: handshake and status bundle between the EIP step
// controller and the fetch/decode/execute units.
// The controller connects through the master modport. The CPU side,
// including test benches, connects through the slave modport.
interface eip_step_controller_if;
  logic        fetch_ack;
  logic [3:0]  num_of_ope;
  logic        exec_done;
  logic        jump_req;
  logic        jump_rel;
  logic [31:0] jump_target;
  logic [31:0] eip;
  logic        fetch_req;
  logic        decode_en;
  logic        exec_en;
  logic        eip_update;
  logic        busy;
  logic        trap;
  logic [31:0] instr_count;

  modport master (
    input  fetch_ack, num_of_ope, exec_done, jump_req, jump_rel, jump_target,
    output eip, fetch_req, decode_en, exec_en, eip_update, busy, trap, instr_count
  );

  modport slave (
    output fetch_ack, num_of_ope, exec_done, jump_req, jump_rel, jump_target,
    input  eip, fetch_req, decode_en, exec_en, eip_update, busy, trap, instr_count
  );
endinterface

// File: rtl/eip_step_controller.sv
// eip_step_controller: single-clock instruction-cycle sequencer.
// It owns EIP and steps the CPU through IDLE/FETCH/DECODE/EXEC/UPDATE.
// EIP advances by the decoded length, or is loaded with an absolute or
// relative jump target, once per instruction.
// Optional feature macro EIP_ILLEGAL_LEN_TRAP_EN: an illegal instruction
// length (0 or 7..15) vectors EIP to TRAP_EIP through a one-cycle TRAP state.
// Without this macro, an illegal length is treated as length 1.
module eip_step_controller #(
  parameter logic [31:0] RESET_EIP = 32'h00000027,
  parameter logic [31:0] TRAP_EIP  = 32'h00000000
) (
  input  logic clock,
  input  logic reset,
  eip_step_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
    S_UPDATE = 3'd4,
    S_TRAP   = 3'd5
`else
    S_UPDATE = 3'd4
`endif
  } state_t;

  state_t             state;
  logic [31:0]        eip_q;
  logic [31:0]        count_q;
  logic [3:0]         len_q;
  logic               jmp_q;
  logic               rel_q;
  logic signed [31:0] tgt_q;

  // Legal x86-style lengths here are 1..6 bytes.
  function automatic logic len_illegal(input logic [3:0] n);
    len_illegal = (n == 4'd0) || (n > 4'd6);
  endfunction

  // Next EIP, modulo 2^32. A relative displacement is taken from the
  // address of the next sequential instruction.
  function automatic logic [31:0] next_eip(
    input logic [31:0]        cur,
    input logic [3:0]         len,
    input logic               jmp,
    input logic               rel,
    input logic signed [31:0] disp
  );
    logic [31:0] seq;
    seq = cur + {28'd0, len};
    if (jmp && !rel)
      next_eip = $unsigned(disp);
    else if (jmp)
      next_eip = seq + $unsigned(disp);
    else
      next_eip = seq;
  endfunction

  // Sequencer: state, EIP, instruction count and latched decode/exec results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      eip_q   <= RESET_EIP;
      count_q <= 32'd0;
      len_q   <= 4'd1;
      jmp_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (bus.fetch_ack) begin
            if (len_illegal(bus.num_of_ope)) begin
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
              eip_q <= TRAP_EIP;
              state <= S_TRAP;
`else
              len_q <= 4'd1;
              state <= S_DECODE;
`endif
            end else begin
              len_q <= bus.num_of_ope;
              state <= S_DECODE;
            end
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (bus.exec_done) begin
            jmp_q <= bus.jump_req;
            rel_q <= bus.jump_rel;
            tgt_q <= bus.jump_target;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          eip_q   <= next_eip(eip_q, len_q, jmp_q, rel_q, tgt_q);
          count_q <= count_q + 32'd1;
          state   <= S_FETCH;
        end
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
        S_TRAP: state <= S_FETCH;
`endif
        default: begin
          // Corrupted state register: restart fetching at the fault vector.
          eip_q <= TRAP_EIP;
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.fetch_req   = (state == S_FETCH);
  assign bus.decode_en   = (state == S_DECODE);
  assign bus.exec_en     = (state == S_EXEC);
  assign bus.eip_update  = (state == S_UPDATE);
  assign bus.busy        = (state != S_IDLE);
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
  assign bus.trap        = (state == S_TRAP);
`else
  assign bus.trap        = 1'b0;
`endif
  assign bus.eip         = eip_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_eip_step_controller.sv
// tb_eip_step_controller: vector table, hand-written corner sequences and
// randomized instructions checked against an instruction-level model.
module tb_eip_step_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;

  eip_step_controller_if bus();

  eip_step_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_eip;
  logic [31:0] exp_cnt;

  typedef struct {
    bit          rst;
    int          fd;
    int          ed;
    logic [3:0]  n;
    logic        jreq;
    logic        jrel;
    logic [31:0] tgt;
    logic [31:0] eip_after;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_eip = 32'h00000027;
    exp_cnt = 32'd0;
  endtask

  // One whole instruction: fetch_ack after fd waiting cycles and exec_done
  // after ed waiting cycles. Other inputs carry random noise when they should
  // be ignored. Ends one cycle after the UPDATE (or TRAP) cycle.
  task automatic do_instr(input int fd, input int ed, input logic [3:0] n,
                          input logic jreq, input logic jrel, input logic [31:0] tgt);
    int f = 0, d = 0, e = 0, u = 0, t = 0, cyc = 0;
    bit fin = 0;
    bit ill;
    logic [31:0] len;
    ill = (n == 4'd0) || (n > 4'd6);
    len = ill ? 32'd1 : {28'd0, n};
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
    if (ill) exp_eip = 32'h00000000;
    else begin
      if (jreq && !jrel) exp_eip = tgt;
      else if (jreq)     exp_eip = exp_eip + len + tgt;
      else               exp_eip = exp_eip + len;
      exp_cnt = exp_cnt + 1;
    end
`else
    if (jreq && !jrel) exp_eip = tgt;
    else if (jreq)     exp_eip = exp_eip + len + tgt;
    else               exp_eip = exp_eip + len;
    exp_cnt = exp_cnt + 1;
`endif
    while (!fin && cyc < 100) begin
      if (bus.fetch_req) begin
        f++;
        bus.fetch_ack  = (f > fd);
        bus.num_of_ope = (f > fd) ? n : 4'($urandom);
      end else begin
        bus.fetch_ack  = 1'($urandom);
        bus.num_of_ope = 4'($urandom);
      end
      if (bus.exec_en) begin
        e++;
        bus.exec_done   = (e > ed);
        bus.jump_req    = (e > ed) ? jreq : 1'($urandom);
        bus.jump_rel    = (e > ed) ? jrel : 1'($urandom);
        bus.jump_target = (e > ed) ? tgt  : $urandom;
      end else begin
        bus.exec_done   = 1'($urandom);
        bus.jump_req    = 1'($urandom);
        bus.jump_rel    = 1'($urandom);
        bus.jump_target = $urandom;
      end
      if (bus.decode_en) d++;
      if (bus.eip_update) begin u++; fin = 1; end
      if (bus.trap) begin t++; fin = 1; end
      @(posedge clock); #1;
      cyc++;
    end
    check("instr_complete", 32'(fin), 32'd1);
    check("eip", bus.eip, exp_eip);
    check("instr_count", bus.instr_count, exp_cnt);
    check("fetch_cycles", 32'(f), 32'(fd + 1));
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
    if (ill) begin
      check("decode_cycles", 32'(d), 32'd0);
      check("exec_cycles", 32'(e), 32'd0);
      check("update_cycles", 32'(u), 32'd0);
      check("trap_cycles", 32'(t), 32'd1);
    end else begin
      check("decode_cycles", 32'(d), 32'd1);
      check("exec_cycles", 32'(e), 32'(ed + 1));
      check("update_cycles", 32'(u), 32'd1);
      check("trap_cycles", 32'(t), 32'd0);
    end
`else
    check("decode_cycles", 32'(d), 32'd1);
    check("exec_cycles", 32'(e), 32'(ed + 1));
    check("update_cycles", 32'(u), 32'd1);
    check("trap_cycles", 32'(t), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{0, 0, 0, 4'd3, 1'b0, 1'b0, 32'h0,        32'h0000002A};
    vecs[1]  = '{0, 0, 0, 4'd3, 1'b0, 1'b0, 32'h0,        32'h0000002D};
    vecs[2]  = '{0, 0, 0, 4'd3, 1'b0, 1'b0, 32'h0,        32'h00000030};
    vecs[3]  = '{0, 5, 3, 4'd2, 1'b0, 1'b0, 32'h0,        32'h00000032};
    vecs[4]  = '{0, 1, 0, 4'd4, 1'b1, 1'b0, 32'h00000100, 32'h00000100};
    vecs[5]  = '{0, 0, 2, 4'd6, 1'b1, 1'b1, 32'h00000008, 32'h0000010E};
    vecs[6]  = '{0, 0, 0, 4'd1, 1'b0, 1'b0, 32'h0,        32'h0000010F};
    vecs[7]  = '{1, 0, 0, 4'd2, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h00000019};
    vecs[8]  = '{0, 0, 0, 4'd5, 1'b1, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE};
    vecs[9]  = '{0, 0, 0, 4'd3, 1'b0, 1'b0, 32'h0,        32'h00000001};
`ifdef EIP_ILLEGAL_LEN_TRAP_EN
    vecs[10] = '{0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0,        32'h00000000};
    vecs[11] = '{0, 0, 0, 4'd9, 1'b0, 1'b0, 32'h0,        32'h00000000};
`else
    vecs[10] = '{0, 0, 0, 4'd0, 1'b0, 1'b0, 32'h0,        32'h00000002};
    vecs[11] = '{0, 0, 0, 4'd9, 1'b0, 1'b0, 32'h0,        32'h00000003};
`endif

    bus.fetch_ack   = 1'b0;
    bus.num_of_ope  = 4'd0;
    bus.exec_done   = 1'b0;
    bus.jump_req    = 1'b0;
    bus.jump_rel    = 1'b0;
    bus.jump_target = 32'd0;

    // Reset state, then first fetch one cycle after release
    repeat (2) @(posedge clock);
    #1;
    check("rst_eip", bus.eip, 32'h00000027);
    check("rst_count", bus.instr_count, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_strobes", {27'd0, bus.fetch_req, bus.decode_en, bus.exec_en, bus.eip_update, bus.trap}, 32'd0);
    reset = 1'b0;
    exp_eip = 32'h00000027;
    exp_cnt = 32'd0;
    @(posedge clock); #1;
    check("first_fetch_req", 32'(bus.fetch_req), 32'd1);
    check("first_busy", 32'(bus.busy), 32'd1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) pulse_reset();
      do_instr(vecs[i].fd, vecs[i].ed, vecs[i].n, vecs[i].jreq, vecs[i].jrel, vecs[i].tgt);
      check($sformatf("vec%0d_eip", i), bus.eip, vecs[i].eip_after);
    end

    // Reset asserted for one cycle while in EXEC
    bus.fetch_ack  = 1'b1;
    bus.num_of_ope = 4'd3;
    bus.exec_done  = 1'b0;
    bus.jump_req   = 1'b1;
    bus.jump_rel   = 1'b0;
    cyc = 0;
    while (!bus.exec_en && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("reach_exec", 32'(bus.exec_en), 32'd1);
    bus.exec_done = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_eip", bus.eip, 32'h00000027);
    check("midrst_count", bus.instr_count, 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_update", 32'(bus.eip_update), 32'd0);
    reset = 1'b0;
    exp_eip = 32'h00000027;
    exp_cnt = 32'd0;
    do_instr(0, 0, 4'd3, 1'b0, 1'b0, 32'h0);
    check("after_midrst_eip", bus.eip, 32'h0000002A);

    // Randomized instructions against the model
    for (int k = 0; k < 40; k++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'($urandom),
               1'($urandom), 1'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
